// File: rtl/bemicrocv_pkg.sv
// Shared board definitions: button/LED polarities and debounce FSM encodings.
package bemicrocv_pkg;

    // Board push-buttons pull low when pressed
    localparam logic TACT_ON  = 1'b0;
    localparam logic TACT_OFF = 1'b1;

    // Board LEDs are lit by a high level
    localparam logic LED_ON   = 1'b1;
    localparam logic LED_OFF  = 1'b0;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

// File: rtl/tact_sync.sv
// Two-flop synchroniser for an asynchronous board button pin.
module tact_sync #(
    parameter logic RST_VAL = bemicrocv_pkg::TACT_OFF
) (
    input  logic CLK_24MHz,
    input  logic RST,
    input  logic pin_async,
    output logic pin_sync
);

    logic s1_q;

    // Two-stage capture; both stages reset to the idle pin level
    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            s1_q     <= RST_VAL;
            pin_sync <= RST_VAL;
        end else begin
            s1_q     <= pin_async;
            pin_sync <= s1_q;
        end
    end

endmodule

// File: rtl/tact_debounce.sv
// Debounces the Tact1 button: clean level, press/release pulses and a long-hold pulse.
module tact_debounce #(
    parameter logic        TACT_ON     = bemicrocv_pkg::TACT_ON,
    parameter int unsigned DB_CYCLES   = 240000,
    parameter int unsigned W_DB        = 18,
    parameter int unsigned LONG_CYCLES = 24000000,
    parameter int unsigned W_LONG      = 25
) (
    input  logic CLK_24MHz,
    input  logic RST,
    input  logic Tact1,
    output logic Tact_clean,
    output logic Tact_level,
    output logic Tact_press,
    output logic Tact_release,
    output logic Tact_long
);

    import bemicrocv_pkg::*;

    localparam logic              TACT_OFF  = ~TACT_ON;
    localparam logic [W_DB-1:0]   DB_LAST   = W_DB'(DB_CYCLES - 1);
    localparam logic [W_LONG-1:0] LONG_LAST = W_LONG'(LONG_CYCLES - 1);

    logic              s;
    db_state_t         state_q, state_d;
    logic [W_DB-1:0]   db_cnt_q, db_cnt_d;
    logic [W_LONG-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              press_d, release_d, long_d;

    tact_sync #(
        .RST_VAL (TACT_OFF)
    ) u_sync (
        .CLK_24MHz (CLK_24MHz),
        .RST       (RST),
        .pin_async (Tact1),
        .pin_sync  (s)
    );

    // Next-state, counter and pulse decode
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        unique case (state_q)
            ST_RELEASED: begin
                if (s == TACT_ON) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (s == TACT_OFF) begin
                    state_d = ST_RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_PRESSED;
                    press_d     = 1'b1;
                    long_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (s == TACT_OFF) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = '0;
                end else if (!long_done_q && long_cnt_q == LONG_LAST) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else if (!long_done_q) begin
                    long_cnt_d = long_cnt_q + 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                // Hold timer is frozen here so a short glitch only delays Tact_long
                if (s == TACT_ON) begin
                    state_d = ST_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    // State, counters and registered pulse outputs
    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            state_q      <= ST_RELEASED;
            db_cnt_q     <= '0;
            long_cnt_q   <= '0;
            long_done_q  <= 1'b0;
            Tact_press   <= 1'b0;
            Tact_release <= 1'b0;
            Tact_long    <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            long_cnt_q   <= long_cnt_d;
            long_done_q  <= long_done_d;
            Tact_press   <= press_d;
            Tact_release <= release_d;
            Tact_long    <= long_d;
        end
    end

    assign Tact_level = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
    assign Tact_clean = Tact_level ? TACT_ON : TACT_OFF;

endmodule

// File: tb/tb_tact_debounce.sv
// Directed bench for tact_debounce with short debounce/long thresholds.
module tb_tact_debounce;

    logic CLK_24MHz;
    logic RST;
    logic Tact1;
    logic Tact_clean;
    logic Tact_level;
    logic Tact_press;
    logic Tact_release;
    logic Tact_long;

    int n_checks = 0;
    int n_fail   = 0;

    tact_debounce #(
        .DB_CYCLES   (4),
        .W_DB        (3),
        .LONG_CYCLES (16),
        .W_LONG      (5)
    ) dut (
        .CLK_24MHz    (CLK_24MHz),
        .RST          (RST),
        .Tact1        (Tact1),
        .Tact_clean   (Tact_clean),
        .Tact_level   (Tact_level),
        .Tact_press   (Tact_press),
        .Tact_release (Tact_release),
        .Tact_long    (Tact_long)
    );

    initial CLK_24MHz = 1'b0;
    always #5 CLK_24MHz = ~CLK_24MHz;

    // Output vector order: {press, release, long, level, clean}
    function automatic logic [4:0] outs();
        return {Tact_press, Tact_release, Tact_long, Tact_level, Tact_clean};
    endfunction

    function automatic logic [4:0] mk(input logic p, input logic r, input logic l,
                                      input logic lv);
        return {p, r, l, lv, ~lv};
    endfunction

    // Step one clock edge and settle just after it
    task automatic tick();
        @(posedge CLK_24MHz);
        #1;
    endtask

    task automatic release_and_settle();
        Tact1 = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        logic [4:0] got;
        RST   = 1'b1;
        Tact1 = 1'b1;
        tick();
        tick();
        got = outs();
        n_checks++;
        if (got !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset outs got %b want %b", got, 5'b00001);
        end
        RST = 1'b0;
        tick();
    endtask

    // Edge i samples the pin low from i=1; press lands after edge 1+4+2 = 7
    task automatic test_clean_press();
        logic [4:0] got, exp;
        Tact1 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            got = outs();
            exp = mk(i == 7, 1'b0, 1'b0, i >= 7);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clean_press i=%0d got %b want %b", i, got, exp);
            end
        end
        release_and_settle();
    endtask

    task automatic test_bounce_reject();
        logic [4:0] got, exp;
        Tact1 = 1'b0;
        exp   = mk(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 4) Tact1 = 1'b1;
            tick();
            got = outs();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bounce_reject i=%0d got %b want %b", i, got, exp);
            end
        end
    endtask

    // Press after edge 7, long 16 edges later at edge 23, never again
    task automatic test_long_hold();
        logic [4:0] got, exp;
        Tact1 = 1'b0;
        for (int i = 1; i <= 47; i++) begin
            tick();
            got = outs();
            exp = mk(i == 7, 1'b0, i == 23, i >= 7);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL long_hold i=%0d got %b want %b", i, got, exp);
            end
        end
        release_and_settle();
    endtask

    // Pin high at edges 10,11: FSM sees it at 12,13 and is back at 14; edges 12..14 add
    // nothing to the hold timer, so Tact_long moves from edge 23 to 26
    task automatic test_release_glitch();
        logic [4:0] got, exp;
        Tact1 = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i == 10) Tact1 = 1'b1;
            if (i == 12) Tact1 = 1'b0;
            tick();
            got = outs();
            exp = mk(i == 7, 1'b0, i == 26, i >= 7);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL release_glitch i=%0d got %b want %b", i, got, exp);
            end
        end
        release_and_settle();
    endtask

    // 10 cycles of hold after the press, then release accepted 6 edges after pin rises
    task automatic test_clean_release();
        logic [4:0] got, exp;
        Tact1 = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            got = outs();
            exp = mk(i == 7, 1'b0, 1'b0, i >= 7);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clean_release hold i=%0d got %b want %b", i, got, exp);
            end
        end
        Tact1 = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            got = outs();
            exp = mk(1'b0, j == 7, 1'b0, j < 7);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clean_release rel j=%0d got %b want %b", j, got, exp);
            end
        end
    endtask

    // Reset while held: history dropped; first post-reset edge samples low, press 6 later
    task automatic test_reset_mid_press();
        logic [4:0] got, exp;
        Tact1 = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        got = outs();
        n_checks++;
        if (got !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_mid_press pre got %b want %b", got, 5'b00010);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        got = outs();
        n_checks++;
        if (got !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_mid_press rst got %b want %b", got, 5'b00001);
        end
        for (int j = 1; j <= 10; j++) begin
            tick();
            got = outs();
            exp = mk(j == 7, 1'b0, 1'b0, j >= 7);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_press j=%0d got %b want %b", j, got, exp);
            end
        end
        release_and_settle();
    endtask

    initial begin
        RST   = 1'b1;
        Tact1 = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_long_hold();
        test_release_glitch();
        test_clean_release();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
